// File: rtl/prbs31_chk_pkg.sv
// -----------------------------------------------------------------------------
// prbs31_chk_pkg
//   Shared constants and types for the PRBS31 (x^31 + x^28 + 1) tiles.
//   The generator tile reuses the tap constants, so keep them here rather
//   than inside the checker.
//
//   Contents:
//     LFSR_W      history / LFSR width (31)
//     TAP_HI      history bit holding the sample from 31 accepted bits ago
//     TAP_LO      history bit holding the sample from 28 accepted bits ago
//     CNT_W       error counter width (16)
//     SEED_W      width of the seed-bit counter (counts 0..LFSR_W-1)
//     chk_state_e checker state {SEED, CHECK}
//     prbs31_pred next expected bit from the history register
// -----------------------------------------------------------------------------
package prbs31_chk_pkg;

    localparam int LFSR_W = 31;
    localparam int TAP_HI = 30;
    localparam int TAP_LO = 27;
    localparam int CNT_W  = 16;
    localparam int SEED_W = $clog2(LFSR_W);

    typedef enum logic {
        SEED  = 1'b0,
        CHECK = 1'b1
    } chk_state_e;

    // s[t] = s[t-28] ^ s[t-31]; with h[0] the newest bit, h[27] is 28 bits
    // back and h[30] is 31 bits back.
    function automatic logic prbs31_pred(input logic [LFSR_W-1:0] hist);
        return hist[TAP_HI] ^ hist[TAP_LO];
    endfunction

endpackage : prbs31_chk_pkg

// File: rtl/prbs31_err_cnt.sv
// -----------------------------------------------------------------------------
// prbs31_err_cnt
//   Saturating error counter for the PRBS31 checker.
//   - Increments on inc_i, sticks at all-ones.
//   - clr_i is synchronous and wins over a simultaneous increment.
//   - sat_o is registered together with the count.
//   - byte_o is a combinational byte select of the registered count.
//
//   Ports:
//     clk_i       clock
//     rst_n_i     asynchronous active-low reset
//     clr_i       synchronous clear of count and saturation flag
//     inc_i       count one error this cycle
//     byte_sel_i  0 = low byte on byte_o, 1 = high byte
//     byte_o      selected count byte
//     sat_o       count is at its maximum
// -----------------------------------------------------------------------------
module prbs31_err_cnt
    import prbs31_chk_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       clr_i,
    input  logic       inc_i,
    input  logic       byte_sel_i,
    output logic [7:0] byte_o,
    output logic       sat_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             sat_q;
    logic             sat_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

    assign byte_o = byte_sel_i ? cnt_q[15:8] : cnt_q[7:0];
    assign sat_o  = sat_q;

endmodule : prbs31_err_cnt

// File: rtl/tt_um_jonathancortez_prbs31_chk.sv
// -----------------------------------------------------------------------------
// tt_um_jonathancortez_prbs31_chk
//   PRBS31 (x^31 + x^28 + 1) receive checker, Tiny Tapeout tile.
//   Seeds its history from the first 31 accepted line bits, then free-runs
//   and compares every accepted bit with its own prediction.
//
//   Ports:
//     clk      clock, all state on the rising edge
//     rst_n    asynchronous active-low reset
//     ena      unused (always 1 on the carrier)
//     ui_in    [0] rx_bit  [1] rx_valid  [2] clr_cnt  [3] byte_sel  [7:4] unused
//     uo_out   [0] locked  [1] err_pulse [2] cnt_sat  [7:3] zero
//     uio_in   unused
//     uio_out  error count byte chosen by byte_sel
//     uio_oe   all outputs (8'hFF)
//
//   Parameters:
//     LOSS_THRESH  errors inside one window that drop lock (1..WINDOW)
//     WINDOW       checked bits per loss-of-lock window (power of 2, 16..256)
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   SEED  | shifting raw line bits into history; 31 bits then try to lock
//   CHECK | locked; history free-runs on its own prediction, errors counted
// -----------------------------------------------------------------------------
module tt_um_jonathancortez_prbs31_chk
    import prbs31_chk_pkg::*;
#(
    parameter int LOSS_THRESH = 8,
    parameter int WINDOW      = 64
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    // Window counters must be able to hold WINDOW itself (e.g. 256 -> 9 bits).
    localparam int                WIN_W     = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW);
    localparam logic [WIN_W-1:0]  LOSS_LAST = WIN_W'(LOSS_THRESH);
    localparam logic [SEED_W-1:0] SEED_LAST = SEED_W'(LFSR_W - 1);

    logic rx_bit;
    logic rx_valid;
    logic clr_cnt;
    logic byte_sel;

    assign rx_bit   = ui_in[0];
    assign rx_valid = ui_in[1];
    assign clr_cnt  = ui_in[2];
    assign byte_sel = ui_in[3];

    logic unused_inputs;
    assign unused_inputs = &{1'b0, ena, uio_in, ui_in[7:4]};

    chk_state_e        state_q;
    chk_state_e        state_d;
    logic [LFSR_W-1:0] hist_q;
    logic [LFSR_W-1:0] hist_d;
    logic [SEED_W-1:0] seed_cnt_q;
    logic [SEED_W-1:0] seed_cnt_d;
    logic [WIN_W-1:0]  win_bits_q;
    logic [WIN_W-1:0]  win_bits_d;
    logic [WIN_W-1:0]  win_errs_q;
    logic [WIN_W-1:0]  win_errs_d;
    logic              err_pulse_q;
    logic              err_pulse_d;

    logic              pred;
    logic              mismatch;
    logic              hist_in;
    logic [LFSR_W-1:0] hist_shift;
    logic [WIN_W-1:0]  win_bits_inc;
    logic [WIN_W-1:0]  win_errs_inc;
    logic              err_inc;

    // In CHECK the history is fed with its own prediction, not the line bit,
    // so a single flipped line bit produces exactly one error instead of
    // corrupting the next 31 predictions.
    assign pred         = prbs31_pred(hist_q);
    assign mismatch     = rx_bit ^ pred;
    assign hist_in      = (state_q == CHECK) ? pred : rx_bit;
    assign hist_shift   = {hist_q[LFSR_W-2:0], hist_in};
    assign win_bits_inc = win_bits_q + 1'b1;
    assign win_errs_inc = win_errs_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        seed_cnt_d  = seed_cnt_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        err_pulse_d = 1'b0;
        err_inc     = 1'b0;

        if (rx_valid) begin
            hist_d = hist_shift;
            case (state_q)
                SEED: begin
                    if (seed_cnt_q == SEED_LAST) begin
                        seed_cnt_d = '0;
                        // An all-zero seed is a stuck line, never a PRBS31
                        // stream; keep collecting instead of locking.
                        if (hist_shift != '0) begin
                            state_d    = CHECK;
                            win_bits_d = '0;
                            win_errs_d = '0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 1'b1;
                    end
                end

                CHECK: begin
                    win_bits_d = win_bits_inc;
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        err_inc     = 1'b1;
                        win_errs_d  = win_errs_inc;
                    end
                    // Loss of lock outranks the window rollover.
                    if (mismatch && (win_errs_inc == LOSS_LAST)) begin
                        state_d    = SEED;
                        seed_cnt_d = '0;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else if (win_bits_inc == WIN_LAST) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end
                end

                default: begin
                    state_d = SEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            hist_q      <= '0;
            seed_cnt_q  <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            seed_cnt_q  <= seed_cnt_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    logic       cnt_sat;
    logic [7:0] cnt_byte;

    prbs31_err_cnt u_err_cnt (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (clr_cnt),
        .inc_i      (err_inc),
        .byte_sel_i (byte_sel),
        .byte_o     (cnt_byte),
        .sat_o      (cnt_sat)
    );

    assign uo_out  = {5'b0, cnt_sat, err_pulse_q, (state_q == CHECK)};
    assign uio_out = cnt_byte;
    assign uio_oe  = 8'hFF;

endmodule : tt_um_jonathancortez_prbs31_chk
